// File: rtl/board_store_seq_pkg.sv
// rtl/board_store_seq_pkg.sv - shared chess definitions: piece codes, square addressing, start layout
// State list gains the undo states when BOARD_UNDO_EN is defined.
package board_store_seq_pkg;

   localparam int SQUARES = 64;
   localparam int PIECE_W = 4;
   localparam int ADDR_W  = 6;

   localparam logic [2:0] PIECE_NONE   = 3'd0;
   localparam logic [2:0] PIECE_PAWN   = 3'd1;
   localparam logic [2:0] PIECE_KNIGHT = 3'd2;
   localparam logic [2:0] PIECE_BISHOP = 3'd3;
   localparam logic [2:0] PIECE_ROOK   = 3'd4;
   localparam logic [2:0] PIECE_QUEEN  = 3'd5;
   localparam logic [2:0] PIECE_KING   = 3'd6;

   localparam logic COLOR_WHITE = 1'b0;
   localparam logic COLOR_BLACK = 1'b1;

   typedef logic [ADDR_W-1:0]  sq_addr_t;
   typedef logic [PIECE_W-1:0] piece_t;

`ifdef BOARD_UNDO_EN
   typedef enum logic [2:0] {
      ST_IDLE, ST_INIT, ST_MV_RD, ST_MV_WDST, ST_MV_WSRC, ST_UNDO_WA, ST_UNDO_WB, ST_FIN
   } state_t;
`else
   typedef enum logic [2:0] {
      ST_IDLE, ST_INIT, ST_MV_RD, ST_MV_WDST, ST_MV_WSRC, ST_FIN
   } state_t;
`endif

   function automatic sq_addr_t sq_addr(input logic [2:0] row, input logic [2:0] col);
      return {row, col};
   endfunction

   // Row 0 is black's back rank, row 7 is white's; both use R N B Q K B N R by column.
   function automatic piece_t init_piece(input sq_addr_t addr);
      logic [2:0] back;
      piece_t     p;
      case (addr[2:0])
         3'd0, 3'd7: back = PIECE_ROOK;
         3'd1, 3'd6: back = PIECE_KNIGHT;
         3'd2, 3'd5: back = PIECE_BISHOP;
         3'd3:       back = PIECE_QUEEN;
         default:    back = PIECE_KING;
      endcase
      case (addr[5:3])
         3'd0:    p = {COLOR_BLACK, back};
         3'd1:    p = {COLOR_BLACK, PIECE_PAWN};
         3'd6:    p = {COLOR_WHITE, PIECE_PAWN};
         3'd7:    p = {COLOR_WHITE, back};
         default: p = {COLOR_WHITE, PIECE_NONE};
      endcase
      return p;
   endfunction

endpackage

// File: rtl/board_store_seq_init_rom.sv
// rtl/board_store_seq_init_rom.sv - combinational square address to start-layout piece lookup
module board_init_rom
   import board_store_seq_pkg::*;
(
   input  logic [ADDR_W-1:0]  addr_i,
   output logic [PIECE_W-1:0] piece_o
);

   assign piece_o = init_piece(sq_addr(addr_i[5:3], addr_i[2:0]));

endmodule

// File: rtl/board_store_seq.sv
// rtl/board_store_seq.sv - 64-square board storage and write sequencer (init sweep, moves, undo)
// Define BOARD_UNDO_EN to add the one-deep undo record and the UNDO_REQ path.
module board_store_seq
   import board_store_seq_pkg::*;
(
   input  logic                       clk_i,
   input  logic                       rst_n_i,
   input  logic                       init_req_i,
   input  logic                       move_req_i,
   input  logic [ADDR_W-1:0]          move_src_i,
   input  logic [ADDR_W-1:0]          move_dst_i,
   input  logic                       undo_req_i,
   input  logic [ADDR_W-1:0]          rd_addr_i,
   output logic [PIECE_W-1:0]         rd_piece_o,
   output logic [SQUARES*PIECE_W-1:0] board_flat_o,
   output logic                       busy_o,
   output logic                       done_o,
   output logic                       reject_o,
   output logic [PIECE_W-1:0]         captured_o
);

   state_t   state_q;
   sq_addr_t cnt_q;
   sq_addr_t src_q;
   sq_addr_t dst_q;
   piece_t   moved_q;
   piece_t   captured_q;
   piece_t   rd_piece_q;
   logic     done_q;
   logic     reject_q;
   piece_t   board_q [SQUARES];

`ifdef BOARD_UNDO_EN
   sq_addr_t u_src_q;
   sq_addr_t u_dst_q;
   piece_t   u_moved_q;
   piece_t   u_capt_q;
   logic     u_valid_q;
`else
   logic     unused_undo_req;
   assign unused_undo_req = undo_req_i;
`endif

   piece_t rom_piece;
   logic   move_bad_d;

   board_init_rom u_rom (
      .addr_i  (cnt_q),
      .piece_o (rom_piece)
   );

   assign move_bad_d = (move_src_i == move_dst_i) || (board_q[move_src_i][2:0] == PIECE_NONE);

   // The cycle carrying REJECT is skipped in IDLE so a still-held request is not refused twice.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q    <= ST_INIT;
         cnt_q      <= '0;
         src_q      <= '0;
         dst_q      <= '0;
         moved_q    <= '0;
         captured_q <= '0;
         rd_piece_q <= '0;
         done_q     <= 1'b0;
         reject_q   <= 1'b0;
         for (int i = 0; i < SQUARES; i++) board_q[i] <= '0;
`ifdef BOARD_UNDO_EN
         u_src_q    <= '0;
         u_dst_q    <= '0;
         u_moved_q  <= '0;
         u_capt_q   <= '0;
         u_valid_q  <= 1'b0;
`endif
      end else begin
         rd_piece_q <= board_q[rd_addr_i];
         done_q     <= 1'b0;
         reject_q   <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (!reject_q) begin
                  if (init_req_i) begin
                     cnt_q   <= '0;
                     state_q <= ST_INIT;
                  end
`ifdef BOARD_UNDO_EN
                  else if (undo_req_i) begin
                     if (u_valid_q) state_q  <= ST_UNDO_WA;
                     else           reject_q <= 1'b1;
                  end
`endif
                  else if (move_req_i) begin
                     if (move_bad_d) begin
                        reject_q <= 1'b1;
                     end else begin
                        src_q   <= move_src_i;
                        dst_q   <= move_dst_i;
                        state_q <= ST_MV_RD;
                     end
                  end
               end
            end
            ST_INIT: begin
               board_q[cnt_q] <= rom_piece;
               cnt_q          <= cnt_q + 1'b1;
`ifdef BOARD_UNDO_EN
               u_valid_q      <= 1'b0;
`endif
               if (cnt_q == sq_addr_t'(SQUARES - 1)) begin
                  done_q  <= 1'b1;
                  state_q <= ST_FIN;
               end
            end
            ST_MV_RD: begin
               moved_q    <= board_q[src_q];
               captured_q <= board_q[dst_q];
               state_q    <= ST_MV_WDST;
            end
            ST_MV_WDST: begin
               board_q[dst_q] <= moved_q;
               state_q        <= ST_MV_WSRC;
            end
            ST_MV_WSRC: begin
               board_q[src_q] <= '0;
`ifdef BOARD_UNDO_EN
               u_src_q   <= src_q;
               u_dst_q   <= dst_q;
               u_moved_q <= moved_q;
               u_capt_q  <= captured_q;
               u_valid_q <= 1'b1;
`endif
               done_q  <= 1'b1;
               state_q <= ST_FIN;
            end
`ifdef BOARD_UNDO_EN
            ST_UNDO_WA: begin
               board_q[u_src_q] <= u_moved_q;
               state_q          <= ST_UNDO_WB;
            end
            ST_UNDO_WB: begin
               board_q[u_dst_q] <= u_capt_q;
               u_valid_q        <= 1'b0;
               done_q           <= 1'b1;
               state_q          <= ST_FIN;
            end
`endif
            ST_FIN:  state_q <= ST_IDLE;
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   for (genvar g = 0; g < SQUARES; g++) begin : g_flat
      assign board_flat_o[g*PIECE_W +: PIECE_W] = board_q[g];
   end

   assign rd_piece_o = rd_piece_q;
   assign busy_o     = (state_q != ST_IDLE);
   assign done_o     = done_q;
   assign reject_o   = reject_q;
   assign captured_o = captured_q;

endmodule

// File: tb/tb_board_store_seq.sv
// tb/tb_board_store_seq.sv - scoreboard bench for board_store_seq against a board-array reference model
module tb_board_store_seq;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         init_req, move_req, undo_req;
   logic [5:0]   move_src, move_dst, rd_addr;
   logic [3:0]   rd_piece_o, captured_o;
   logic [255:0] board_flat_o;
   logic         busy_o, done_o, reject_o;

   always #5 clk = ~clk;

   board_store_seq dut (
      .clk_i        (clk),
      .rst_n_i      (rst_n),
      .init_req_i   (init_req),
      .move_req_i   (move_req),
      .move_src_i   (move_src),
      .move_dst_i   (move_dst),
      .undo_req_i   (undo_req),
      .rd_addr_i    (rd_addr),
      .rd_piece_o   (rd_piece_o),
      .board_flat_o (board_flat_o),
      .busy_o       (busy_o),
      .done_o       (done_o),
      .reject_o     (reject_o),
      .captured_o   (captured_o)
   );

   typedef struct {
      bit           is_rej;
      int           lat;
      logic [255:0] flat;
      logic [3:0]   cap;
      int           issue;
      string        name;
   } exp_t;

   exp_t       sbq[$];
   exp_t       mon_e;
   int         vectors = 0;
   int         miscompares = 0;
   int         cyc = 0;
   logic [3:0] mb [64];
   logic [3:0] mcap;
   bit         u_valid;
   int         u_src, u_dst;
   logic [3:0] u_moved, u_cap;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [3:0] start_sq(input int sq);
      string      back = "RNBQKBNR";
      int         row = sq / 8;
      int         col = sq % 8;
      logic [2:0] kind;
      case (back[col])
         "R":     kind = 3'd4;
         "N":     kind = 3'd2;
         "B":     kind = 3'd3;
         "Q":     kind = 3'd5;
         default: kind = 3'd6;
      endcase
      if (row == 0) return {1'b1, kind};
      if (row == 1) return 4'b1001;
      if (row == 6) return 4'b0001;
      if (row == 7) return {1'b0, kind};
      return 4'b0000;
   endfunction

   function automatic logic [255:0] model_flat();
      logic [255:0] f;
      for (int i = 0; i < 64; i++) f[i*4 +: 4] = mb[i];
      return f;
   endfunction

   task automatic model_init();
      for (int i = 0; i < 64; i++) mb[i] = start_sq(i);
      u_valid = 0;
   endtask

   task automatic push(input bit rej, input int lat, input string nm);
      exp_t e;
      e.is_rej = rej;
      e.lat    = lat;
      e.flat   = model_flat();
      e.cap    = mcap;
      e.issue  = cyc;
      e.name   = nm;
      sbq.push_back(e);
   endtask

   // Monitor: every DONE/REJECT pulse is matched against the oldest expectation.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1 && (done_o === 1'b1 || reject_o === 1'b1)) begin
            if (sbq.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL unexpected_event: done=%0b reject=%0b with nothing expected", done_o, reject_o);
            end else begin
               mon_e = sbq.pop_front();
               chk({mon_e.name, "_reject"},   reject_o,         mon_e.is_rej);
               chk({mon_e.name, "_done"},     done_o,           !mon_e.is_rej);
               chk({mon_e.name, "_latency"},  cyc - mon_e.issue, mon_e.lat);
               chk({mon_e.name, "_busy"},     busy_o,           !mon_e.is_rej);
               chk({mon_e.name, "_board"},    board_flat_o,     mon_e.flat);
               chk({mon_e.name, "_captured"}, captured_o,       mon_e.cap);
            end
         end
      end
   end

   task automatic wait_evt();
      bit ok = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (done_o === 1'b1 || reject_o === 1'b1) begin
            ok = 1;
            break;
         end
      end
      if (!ok) begin
         vectors++;
         miscompares++;
         $display("FAIL timeout: no done/reject within 300 cycles, got none expected one");
      end
   endtask

   task automatic do_move(input int src, input int dst);
      move_src = 6'(src);
      move_dst = 6'(dst);
      move_req = 1'b1;
      if (src == dst || mb[src][2:0] == 3'd0) begin
         push(1, 1, "move_rej");
      end else begin
         mcap    = mb[dst];
         u_src   = src;
         u_dst   = dst;
         u_moved = mb[src];
         u_cap   = mb[dst];
         u_valid = 1;
         mb[dst] = mb[src];
         mb[src] = 4'b0000;
         push(0, 4, "move");
      end
      wait_evt();
      move_req = 1'b0;
      @(negedge clk);
   endtask

   task automatic do_init();
      init_req = 1'b1;
      model_init();
      push(0, 65, "init");
      wait_evt();
      init_req = 1'b0;
      @(negedge clk);
   endtask

   task automatic do_undo();
`ifdef BOARD_UNDO_EN
      undo_req = 1'b1;
      if (u_valid) begin
         mb[u_src] = u_moved;
         mb[u_dst] = u_cap;
         u_valid   = 0;
         push(0, 3, "undo");
      end else begin
         push(1, 1, "undo_rej");
      end
      wait_evt();
      undo_req = 1'b0;
      @(negedge clk);
`else
      undo_req = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("undo_ignored_busy", busy_o, 0);
      end
      undo_req = 1'b0;
      @(negedge clk);
`endif
   endtask

   task automatic rd_check(input int n);
      int a;
      for (int i = 0; i < n; i++) begin
         a       = $urandom_range(0, 63);
         rd_addr = 6'(a);
         @(negedge clk);
         chk("rd_piece", rd_piece_o, mb[a]);
      end
   endtask

   initial begin
      int src, dst, r;
      rst_n    = 1'b0;
      init_req = 1'b0;
      move_req = 1'b0;
      undo_req = 1'b0;
      move_src = '0;
      move_dst = '0;
      rd_addr  = '0;
      for (int i = 0; i < 64; i++) mb[i] = 4'b0000;
      mcap = 4'b0000;
      u_valid = 0;
      repeat (3) @(negedge clk);
      chk("reset_busy",     busy_o,       1);
      chk("reset_done",     done_o,       0);
      chk("reset_reject",   reject_o,     0);
      chk("reset_captured", captured_o,   0);
      chk("reset_rd_piece", rd_piece_o,   0);
      chk("reset_board",    board_flat_o, 0);

      // Power-up init sweep runs without any request.
      model_init();
      push(0, 64, "reset_init");
      rst_n = 1'b1;
      wait_evt();
      @(negedge clk);
      rd_check(4);

      do_move(52, 36);
      do_move(20, 28);
      do_move(8, 8);
      do_move(52, 44);
      chk("idle_after_reject", busy_o, 0);

      // Simultaneous init and move: init wins, the held move follows.
      init_req = 1'b1;
      move_req = 1'b1;
      move_src = 6'd51;
      move_dst = 6'd35;
      model_init();
      push(0, 65, "prio_init");
      mcap = mb[35];
      u_src = 51; u_dst = 35; u_moved = mb[51]; u_cap = mb[35]; u_valid = 1;
      mb[35] = mb[51];
      mb[51] = 4'b0000;
      push(0, 70, "prio_move");
      wait_evt();
      init_req = 1'b0;
      wait_evt();
      move_req = 1'b0;
      @(negedge clk);

      // Capture aborted by a one-cycle reset while writing the destination.
      do_move(12, 28);
      move_src = 6'd35;
      move_dst = 6'd28;
      move_req = 1'b1;
      repeat (2) @(negedge clk);
      rst_n    = 1'b0;
      move_req = 1'b0;
      @(negedge clk);
      model_init();
      mcap = 4'b0000;
      push(0, 64, "reset_mid_init");
      rst_n = 1'b1;
      wait_evt();
      @(negedge clk);

      do_move(57, 42);
      do_undo();
      do_undo();
      rd_check(4);

      for (int it = 0; it < 40; it++) begin
         r = $urandom_range(0, 19);
         if (r == 0) begin
            do_init();
         end else if (r < 4) begin
            do_undo();
         end else begin
            src = $urandom_range(0, 63);
            if ($urandom_range(0, 9) < 8)
               for (int t = 0; t < 64 && mb[src][2:0] == 3'd0; t++) src = $urandom_range(0, 63);
            dst = ($urandom_range(0, 9) == 0) ? src : $urandom_range(0, 63);
            do_move(src, dst);
         end
      end
      rd_check(6);

      repeat (5) @(negedge clk);
      chk("scoreboard_drain", sbq.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
